// File: rtl/penguen_pkg.sv
// rtl/penguen_pkg.sv - shared FSM state enum and width helpers for penguen_kolonisi
package penguen_pkg;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        AV    = 2'd1,
        HESAP = 2'd2,
        SONUC = 2'd3
    } durum_e;

    // width of a 1-based penguin index
    function automatic int idx_w(input int n);
        return $clog2(n + 1);
    endfunction

    // width that holds the sum of all finish times
    function automatic int toplam_w(input int sure_w, input int n);
        return sure_w + $clog2(n);
    endfunction

endpackage

// File: rtl/ardisik_bolucu.sv
// rtl/ardisik_bolucu.sv - restoring shift-subtract divider by a constant, one quotient bit per cycle
module ardisik_bolucu #(
    parameter int W     = 10,
    parameter int BOLEN = 5
) (
    input  logic         saat,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bolunen,
    output logic         done,
    output logic [W-1:0] bolum
);
    localparam int         CNT_W   = $clog2(W + 1);
    localparam logic [W:0] BOLEN_V = (W + 1)'(BOLEN);

    logic [W-1:0]     kalan_q, kalan_d;
    logic [W-1:0]     bolum_q, bolum_d;
    logic [CNT_W-1:0] sayac_q, sayac_d;
    logic [W:0]       kaydir;

    // load on start, then shift one dividend bit into the remainder per cycle
    always_comb begin
        kalan_d = kalan_q;
        bolum_d = bolum_q;
        sayac_d = sayac_q;
        kaydir  = {kalan_q, bolum_q[W-1]};
        if (start) begin
            kalan_d = '0;
            bolum_d = bolunen;
            sayac_d = CNT_W'(W);
        end else if (sayac_q != '0) begin
            if (kaydir >= BOLEN_V) begin
                kalan_d = W'(kaydir - BOLEN_V);
                bolum_d = {bolum_q[W-2:0], 1'b1};
            end else begin
                kalan_d = kaydir[W-1:0];
                bolum_d = {bolum_q[W-2:0], 1'b0};
            end
            sayac_d = sayac_q - CNT_W'(1);
        end
    end

    // done marks the cycle that produces the last quotient bit; bolum is that final value
    assign done  = (sayac_q == CNT_W'(1));
    assign bolum = bolum_d;

    // divider state registers
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            kalan_q <= '0;
            bolum_q <= '0;
            sayac_q <= '0;
        end else begin
            kalan_q <= kalan_d;
            bolum_q <= bolum_d;
            sayac_q <= sayac_d;
        end
    end

endmodule

// File: rtl/penguen_kolonisi.sv
// rtl/penguen_kolonisi.sv - penguin fishing race timer with min/max/mean statistics; optional ZAMAN_ASIMI_EN
module penguen_kolonisi
    import penguen_pkg::*;
#(
    parameter int N_PENGUEN = 5,
    parameter int BALIK_W   = 3,
    parameter int HEDEF     = 12,
    parameter int SURE_W    = 7
) (
    input  logic                           saat,
    input  logic                           reset,
    input  logic                           basla,
    input  logic [N_PENGUEN*BALIK_W-1:0]   avlanan_balik,
    input  logic                           sonuc_al,
    output logic                           mesgul,
    output logic                           bitti,
    output logic                           zaman_asimi,
    output logic [SURE_W-1:0]              en_kisa,
    output logic [SURE_W-1:0]              en_uzun,
    output logic [SURE_W-1:0]              ortalama,
    output logic [idx_w(N_PENGUEN)-1:0]    hizli_penguen,
    output logic [idx_w(N_PENGUEN)-1:0]    yavas_penguen
);
    localparam int                IDX_W    = idx_w(N_PENGUEN);
    localparam int                TOPLAM_W = toplam_w(SURE_W, N_PENGUEN);
    localparam int                ACC_W    = 8;
    localparam logic [ACC_W-1:0]  HEDEF_A  = ACC_W'(HEDEF);
    localparam logic [SURE_W-1:0] SURE_MAX = '1;

    durum_e                            state_q, state_d;
    logic [N_PENGUEN-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [N_PENGUEN-1:0][SURE_W-1:0]  sure_q, sure_d;
    logic [SURE_W-1:0]                 en_kisa_q, en_kisa_d, en_uzun_q, en_uzun_d;
    logic [SURE_W-1:0]                 ortalama_q, ortalama_d;
    logic [IDX_W-1:0]                  hizli_q, hizli_d, yavas_q, yavas_d;
    logic                              all_done, zorla;
    logic [TOPLAM_W-1:0]               toplam, bolum;
    logic                              div_start, div_done;
    logic [SURE_W-1:0]                 min_t, max_t;
    logic [IDX_W-1:0]                  min_i, max_i;
    int                                yeni;

    // per-penguin catch accumulation and time counting; the sum feeds the divider
    always_comb begin
        acc_d    = acc_q;
        sure_d   = sure_q;
        all_done = 1'b1;
        zorla    = 1'b0;
        toplam   = '0;
        yeni     = 0;
        for (int i = 0; i < N_PENGUEN; i++) begin
            if (state_q == BOS) begin
                acc_d[i]  = '0;
                sure_d[i] = '0;
            end else if (state_q == AV && acc_q[i] < HEDEF_A) begin
                yeni     = int'(acc_q[i]) + int'(avlanan_balik[i*BALIK_W +: BALIK_W]);
                acc_d[i] = (yeni >= HEDEF) ? HEDEF_A : ACC_W'(yeni);
                if (sure_q[i] != SURE_MAX) sure_d[i] = sure_q[i] + SURE_W'(1);
            end
            if (acc_d[i] < HEDEF_A) begin
                all_done = 1'b0;
`ifdef ZAMAN_ASIMI_EN
                if (sure_d[i] == SURE_MAX) zorla = 1'b1;
`endif
            end
            toplam = toplam + TOPLAM_W'(sure_d[i]);
        end
    end

    // fastest/slowest search over frozen times; ties go to the highest index
    always_comb begin
        min_t = sure_q[0];
        max_t = sure_q[0];
        min_i = IDX_W'(1);
        max_i = IDX_W'(1);
        for (int i = 1; i < N_PENGUEN; i++) begin
            if (sure_q[i] <= min_t) begin
                min_t = sure_q[i];
                min_i = IDX_W'(i + 1);
            end
            if (sure_q[i] >= max_t) begin
                max_t = sure_q[i];
                max_i = IDX_W'(i + 1);
            end
        end
    end

    // race sequencing; the divider is started on the edge that leaves AV
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        case (state_q)
            BOS:     if (basla) state_d = AV;
            AV: begin
                if (all_done || zorla) begin
                    state_d   = HESAP;
                    div_start = 1'b1;
                end
            end
            HESAP:   if (div_done) state_d = SONUC;
            SONUC:   if (sonuc_al) state_d = BOS;
            default: state_d = BOS;
        endcase
    end

    // result registers update only when the mean is ready, and otherwise hold
    always_comb begin
        en_kisa_d  = en_kisa_q;
        en_uzun_d  = en_uzun_q;
        ortalama_d = ortalama_q;
        hizli_d    = hizli_q;
        yavas_d    = yavas_q;
        if (state_q == HESAP && div_done) begin
            en_kisa_d  = min_t;
            en_uzun_d  = max_t;
            ortalama_d = SURE_W'(bolum);
            hizli_d    = min_i;
            yavas_d    = max_i;
        end
    end

    // state, race and result registers
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            state_q    <= BOS;
            acc_q      <= '0;
            sure_q     <= '0;
            en_kisa_q  <= '0;
            en_uzun_q  <= '0;
            ortalama_q <= '0;
            hizli_q    <= '0;
            yavas_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            sure_q     <= sure_d;
            en_kisa_q  <= en_kisa_d;
            en_uzun_q  <= en_uzun_d;
            ortalama_q <= ortalama_d;
            hizli_q    <= hizli_d;
            yavas_q    <= yavas_d;
        end
    end

`ifdef ZAMAN_ASIMI_EN
    logic tmo_q, tmo_d;

    // remember that the race was cut short by the time limit
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == BOS) tmo_d = 1'b0;
        else if (state_q == AV && !all_done && zorla) tmo_d = 1'b1;
    end

    // timeout flag register
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) tmo_q <= 1'b0;
        else        tmo_q <= tmo_d;
    end

    assign zaman_asimi = tmo_q && (state_q == SONUC);
`else
    assign zaman_asimi = 1'b0;
`endif

    ardisik_bolucu #(
        .W     (TOPLAM_W),
        .BOLEN (N_PENGUEN)
    ) u_bolucu (
        .saat    (saat),
        .reset   (reset),
        .start   (div_start),
        .bolunen (toplam),
        .done    (div_done),
        .bolum   (bolum)
    );

    assign mesgul        = (state_q == AV) || (state_q == HESAP);
    assign bitti         = (state_q == SONUC);
    assign en_kisa       = en_kisa_q;
    assign en_uzun       = en_uzun_q;
    assign ortalama      = ortalama_q;
    assign hizli_penguen = hizli_q;
    assign yavas_penguen = yavas_q;

endmodule
